// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Brief    : Shared state encodings and sizing helper for the parametrised
//            serial pattern detector.
// Revision : 1.0  initial release
// ============================================================================
package seq_det_pkg;

  // State register width and encodings (kept as plain constants so older
  // blocks that compare raw state values keep working).
  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_FILL  = 2'b00;
  localparam logic [ST_W-1:0] ST_HUNT  = 2'b01;
  localparam logic [ST_W-1:0] ST_MATCH = 2'b10;

  // Bits needed to hold a fill count of 0..w inclusive.
  function automatic int fill_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_det_match_cnt.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_match_cnt
// Brief    : Saturating match counter with synchronous clear. Clear has
//            priority over increment. Only built when SEQ_DET_CNT_EN is
//            defined for the detector top.
// Revision : 1.0  initial release
// ============================================================================
module seq_det_match_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             INC,
  output logic [CNT_W-1:0] CNT
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  // Count matches, hold at the top value, clear on request.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (CLR) begin
      r_cnt <= '0;
    end else if (INC && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + c_CNT_ONE;
    end
  end

  assign CNT = r_cnt;

endmodule : seq_det_match_cnt
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Brief    : Runtime-programmable serial bit-pattern detector. Shifts in one
//            qualified bit per cycle, compares the last PATTERN_W bits with a
//            loadable pattern and raises a one-cycle Moore match flag.
//            Overlapping or non-overlapping operation via OVERLAP.
//            Optional saturating match counter: define SEQ_DET_CNT_EN.
//            Without it MATCH_CNT reads 0 and CNT_CLR is ignored.
// Revision : 1.0  initial release
// ============================================================================
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   CNT_W     = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN,
  input  logic                 IN_VLD,
  input  logic                 PAT_LOAD,
  input  logic [PATTERN_W-1:0] PAT_IN,
  input  logic                 CNT_CLR,
  output logic                 OUT,
  output logic [CNT_W-1:0]     MATCH_CNT
);

  localparam int                  c_FILL_W   = fill_width(PATTERN_W);
  localparam logic [c_FILL_W-1:0] c_FILL_MAX = c_FILL_W'(PATTERN_W);
  localparam logic [c_FILL_W-1:0] c_FILL_ONE = c_FILL_W'(1);

  logic [PATTERN_W-1:0] r_pat;
  logic [PATTERN_W-1:0] r_hist;
  logic [c_FILL_W-1:0]  r_fill;
  logic [ST_W-1:0]      r_state;

  logic [PATTERN_W-1:0] w_pat_nxt;
  logic [PATTERN_W-1:0] w_hist_nxt;
  logic [c_FILL_W-1:0]  w_fill_nxt;
  logic [ST_W-1:0]      w_state_nxt;

  logic [PATTERN_W-1:0] w_hist_shift;
  logic [c_FILL_W-1:0]  w_fill_inc;
  logic                 w_hit;
  logic [ST_W-1:0]      w_state_eval;

  // Candidate history/fill after accepting the current bit, and the state a
  // hunting detector would move to with it.
  assign w_hist_shift = {r_hist[PATTERN_W-2:0], IN};
  assign w_fill_inc   = (r_fill == c_FILL_MAX) ? c_FILL_MAX : (r_fill + c_FILL_ONE);
  assign w_hit        = (w_fill_inc == c_FILL_MAX) && (w_hist_shift == r_pat);
  assign w_state_eval = w_hit ? ST_MATCH :
                        (w_fill_inc == c_FILL_MAX) ? ST_HUNT : ST_FILL;

  // Next-state, history and pattern update; a pattern load overrides any bit.
  always_comb begin
    w_pat_nxt   = r_pat;
    w_hist_nxt  = r_hist;
    w_fill_nxt  = r_fill;
    w_state_nxt = r_state;
    if (PAT_LOAD) begin
      w_pat_nxt   = PAT_IN;
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
      w_state_nxt = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL, ST_HUNT: begin
          if (IN_VLD) begin
            w_hist_nxt  = w_hist_shift;
            w_fill_nxt  = w_fill_inc;
            w_state_nxt = w_state_eval;
          end
        end
        ST_MATCH: begin
          if (IN_VLD) begin
            if (OVERLAP) begin
              w_hist_nxt  = w_hist_shift;
              w_fill_nxt  = w_fill_inc;
              w_state_nxt = w_state_eval;
            end else begin
              // Matched bits are consumed: the new bit starts a fresh window.
              w_hist_nxt    = '0;
              w_hist_nxt[0] = IN;
              w_fill_nxt    = c_FILL_ONE;
              w_state_nxt   = ST_FILL;
            end
          end else if (OVERLAP) begin
            w_state_nxt = ST_HUNT;
          end else begin
            w_fill_nxt  = '0;
            w_state_nxt = ST_FILL;
          end
        end
        default: begin
          w_state_nxt = ST_FILL;
        end
      endcase
    end
  end

  // Detector state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_pat   <= PATTERN;
      r_hist  <= '0;
      r_fill  <= '0;
      r_state <= ST_FILL;
    end else begin
      r_pat   <= w_pat_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_state <= w_state_nxt;
    end
  end

  // Match flag is a pure decode of the registered state.
  assign OUT = (r_state == ST_MATCH);

`ifdef SEQ_DET_CNT_EN
  logic w_cnt_inc;

  assign w_cnt_inc = (w_state_nxt == ST_MATCH);

  seq_det_match_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .CLK (CLK),
    .RST (RST),
    .CLR (CNT_CLR),
    .INC (w_cnt_inc),
    .CNT (MATCH_CNT)
  );
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = CNT_CLR;
  assign MATCH_CNT        = '0;
`endif

endmodule : seq_detector_param
`default_nettype wire
